// File: rtl/ysyx_040729_trap_ctrl.sv
// ----------------------------------------------------------------------------
// ysyx_040729_trap_ctrl
//   Machine-mode trap/return sequencer sitting at the commit boundary.
//   On an accepted interrupt or ECALL it writes mepc, mcause and mstatus
//   one per cycle, then asks fetch to redirect to the trap vector. On MRET it
//   restores mstatus and redirects to mepc. The pipeline is stalled for the
//   whole sequence.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   inst_valid        instruction present at the commit boundary
//   inst_pc           PC of that instruction
//   ecall, mret       instruction kind, qualified by inst_valid
//   ext_irq, tmr_irq  interrupt pending levels
//   meie, mtie        per-source interrupt enables (mie CSR)
//   mtvec, mepc_in    current trap vector and mepc CSR values
//   redirect_ready    fetch accepts the redirect
//   stall             freeze pipeline / block commit
//   csr_we/waddr/wdata  single-port CSR write strobe, address, data
//   redirect_valid/pc   PC redirect request and target
//   mstatus_mie/mpie  internally held mstatus.MIE / mstatus.MPIE
// ----------------------------------------------------------------------------
module ysyx_040729_trap_ctrl #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inst_valid,
    input  logic [DATA_WIDTH-1:0] inst_pc,
    input  logic                  ecall,
    input  logic                  mret,
    input  logic                  ext_irq,
    input  logic                  tmr_irq,
    input  logic                  meie,
    input  logic                  mtie,
    input  logic [DATA_WIDTH-1:0] mtvec,
    input  logic [DATA_WIDTH-1:0] mepc_in,
    input  logic                  redirect_ready,
    output logic                  stall,
    output logic                  csr_we,
    output logic [11:0]           csr_waddr,
    output logic [DATA_WIDTH-1:0] csr_wdata,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  mstatus_mie,
    output logic                  mstatus_mpie
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        T_EPC    = 3'd1,
        T_CAUSE  = 3'd2,
        T_STATUS = 3'd3,
        R_STATUS = 3'd4,
        REDIR    = 3'd5
    } state_t;

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

    // mcause layout: interrupt flag in the MSB, exception code in [3:0].
    function automatic logic [DATA_WIDTH-1:0] make_cause(input logic irq, input logic [3:0] code);
        logic [DATA_WIDTH-1:0] c;
        c = '0;
        c[DATA_WIDTH-1] = irq;
        c[3:0] = code;
        return c;
    endfunction

    state_t                state_r, next_state_s;
    logic [DATA_WIDTH-1:0] pc_r, pc_next_s;
    logic [DATA_WIDTH-1:0] cause_r, cause_next_s;
    logic [DATA_WIDTH-1:0] target_r, target_next_s;
    logic                  mie_r, mie_next_s;
    logic                  mpie_r, mpie_next_s;

    logic                  ev_valid_s;
    logic                  ext_take_s, tmr_take_s, ecall_take_s, mret_take_s;
    logic [DATA_WIDTH-1:0] vec_base_s, vec_off_s, trap_target_s;

    // rst_n is folded in so stall stays low while reset is held.
    assign ev_valid_s   = inst_valid & rst_n;
    assign ext_take_s   = ev_valid_s & ext_irq & meie & mie_r;
    assign tmr_take_s   = ev_valid_s & tmr_irq & mtie & mie_r;
    assign ecall_take_s = ev_valid_s & ecall;
    assign mret_take_s  = ev_valid_s & mret;

    // Vectored mode only applies to interrupts; exceptions always use the base.
    assign vec_base_s    = {mtvec[DATA_WIDTH-1:2], 2'b00};
    assign vec_off_s     = DATA_WIDTH'({cause_r[3:0], 2'b00});
    assign trap_target_s = ((mtvec[1:0] == 2'b01) && cause_r[DATA_WIDTH-1])
                         ? (vec_base_s + vec_off_s) : vec_base_s;

    // Next-state, datapath updates and output decode of the sequencer.
    always_comb begin
        next_state_s     = state_r;
        pc_next_s        = pc_r;
        cause_next_s     = cause_r;
        target_next_s    = target_r;
        mie_next_s       = mie_r;
        mpie_next_s      = mpie_r;
        stall            = 1'b0;
        csr_we           = 1'b0;
        csr_waddr        = 12'h000;
        csr_wdata        = '0;
        redirect_valid   = 1'b0;
        redirect_pc      = '0;
        case (state_r)
            IDLE: begin
                if (ext_take_s) begin
                    stall        = 1'b1;
                    cause_next_s = make_cause(1'b1, 4'hB);
                    pc_next_s    = inst_pc;
                    next_state_s = T_EPC;
                end else if (tmr_take_s) begin
                    stall        = 1'b1;
                    cause_next_s = make_cause(1'b1, 4'h7);
                    pc_next_s    = inst_pc;
                    next_state_s = T_EPC;
                end else if (ecall_take_s) begin
                    stall        = 1'b1;
                    cause_next_s = make_cause(1'b0, 4'hB);
                    pc_next_s    = inst_pc;
                    next_state_s = T_EPC;
                end else if (mret_take_s) begin
                    stall        = 1'b1;
                    next_state_s = R_STATUS;
                end else begin
                    next_state_s = IDLE;
                end
            end
            T_EPC: begin
                stall        = 1'b1;
                csr_we       = 1'b1;
                csr_waddr    = ADDR_MEPC;
                csr_wdata    = pc_r;
                next_state_s = T_CAUSE;
            end
            T_CAUSE: begin
                stall        = 1'b1;
                csr_we       = 1'b1;
                csr_waddr    = ADDR_MCAUSE;
                csr_wdata    = cause_r;
                next_state_s = T_STATUS;
            end
            T_STATUS: begin
                stall         = 1'b1;
                csr_we        = 1'b1;
                csr_waddr     = ADDR_MSTATUS;
                csr_wdata[7]  = mie_r;
                mpie_next_s   = mie_r;
                mie_next_s    = 1'b0;
                target_next_s = trap_target_s;
                next_state_s  = REDIR;
            end
            R_STATUS: begin
                stall         = 1'b1;
                csr_we        = 1'b1;
                csr_waddr     = ADDR_MSTATUS;
                csr_wdata[7]  = 1'b1;
                csr_wdata[3]  = mpie_r;
                mie_next_s    = mpie_r;
                mpie_next_s   = 1'b1;
                target_next_s = mepc_in;
                next_state_s  = REDIR;
            end
            REDIR: begin
                stall          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = target_r;
                if (redirect_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = REDIR;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State and latched trap context registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            pc_r     <= '0;
            cause_r  <= '0;
            target_r <= '0;
            mie_r    <= 1'b0;
            mpie_r   <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            pc_r     <= pc_next_s;
            cause_r  <= cause_next_s;
            target_r <= target_next_s;
            mie_r    <= mie_next_s;
            mpie_r   <= mpie_next_s;
        end
    end

    assign mstatus_mie  = mie_r;
    assign mstatus_mpie = mpie_r;

endmodule

// File: doc/ysyx_040729_trap_ctrl.md
YSYX_040729_TRAP_CTRL -- requirements
Module: ysyx_040729_trap_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, register/PC width.
REQ-002 SHALL have ports, in order:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- inst_valid  in  1  instruction present at commit boundary.
- inst_pc  in  DATA_WIDTH  PC of that instruction.
- ecall  in  1  instruction is ECALL; qualified by inst_valid.
- mret  in  1  instruction is MRET; qualified by inst_valid.
- ext_irq  in  1  external interrupt pending level.
- tmr_irq  in  1  timer interrupt pending level.
- meie  in  1  mie.MEIE enable.
- mtie  in  1  mie.MTIE enable.
- mtvec  in  DATA_WIDTH  trap vector CSR value.
- mepc_in  in  DATA_WIDTH  current mepc CSR value.
- redirect_ready  in  1  fetch accepts redirect.
- stall  out  1  freeze pipeline / block commit.
- csr_we  out  1  CSR write strobe.
- csr_waddr  out  12  CSR address.
- csr_wdata  out  DATA_WIDTH  CSR write data.
- redirect_valid  out  1  PC redirect request.
- redirect_pc  out  DATA_WIDTH  redirect target.
- mstatus_mie  out  1  internal mstatus.MIE.
- mstatus_mpie  out  1  internal mstatus.MPIE.

Function
REQ-003 SHALL hold states IDLE, T_EPC, T_CAUSE, T_STATUS, R_STATUS, REDIR; 3-bit encoded.
REQ-004 SHALL evaluate events only in IDLE with inst_valid=1; priority ext_irq&meie&MIE > tmr_irq&mtie&MIE > ecall > mret.
REQ-005 SHALL, on accepting a trap, latch cause: ext {1,...,0xB}, tmr {1,...,0x7}, ecall {0,...,0xB} (MSB=interrupt bit, bits[3:0]=code, rest 0), latch inst_pc; next state T_EPC.
REQ-006 SHALL, on accepting mret, go to R_STATUS.
REQ-007 SHALL assert stall combinationally in the accepting IDLE cycle and in every non-IDLE state.
REQ-008 T_EPC: csr_we=1, addr 0x341, data=latched pc; next T_CAUSE.
REQ-009 T_CAUSE: csr_we=1, addr 0x342, data=latched cause; next T_STATUS.
REQ-010 T_STATUS: MPIE<=MIE, MIE<=0; csr_we=1, addr 0x300, data bit7=old MIE, bit3=0, else 0; next REDIR.
REQ-011 R_STATUS: MIE<=MPIE, MPIE<=1; csr_we=1, addr 0x300, data bit7=1, bit3=old MPIE; next REDIR.
REQ-012 REDIR (trap): redirect_pc={mtvec[W-1:2],00} if mtvec[1:0]!=01 or cause is exception; else that base + 4*code.
REQ-013 REDIR (mret): redirect_pc=mepc_in sampled in R_STATUS cycle, registered.
REQ-014 REDIR: redirect_valid=1 and redirect_pc stable until redirect_ready=1; handshake cycle -> IDLE, stall deasserts next cycle.
REQ-015 csr_we SHALL be 0 in IDLE and REDIR; exactly one CSR write per write state.
REQ-016 Interrupt inputs SHALL be ignored outside IDLE; changes of ext_irq/tmr_irq mid-sequence do not alter latched cause.
REQ-017 Interrupt simultaneous with ecall/mret: interrupt wins; mepc=inst_pc so instruction re-executes.
REQ-018 ecall and mret both high: ecall wins.
REQ-019 Trap latency: accept cycle to redirect_valid = 4 cycles; mret = 2 cycles.
REQ-020 inst_valid=0: no event accepted regardless of other inputs.

Reset
REQ-021 rst_n low SHALL force state IDLE, MIE=0, MPIE=0, latched pc/cause/target 0, all outputs 0, immediately.
REQ-022 Reset mid-sequence SHALL abort; no further CSR writes or redirect after release.
REQ-023 After reset, interrupts are masked until MIE is set via an mret path.

Verification
REQ-024 Reset, then ecall at pc 0x8000_0010, MIE=0, mtvec 0x8000_0100 -> writes 0x341=0x80000010, 0x342=0xB, 0x300=0x0; redirect 0x8000_0100 at cycle+4.
REQ-025 MPIE=1 via reset then mret, mepc_in 0x8000_0014 -> 0x300 write 0x88, MIE=1, redirect 0x8000_0014 at cycle+2.
REQ-026 MIE=1, meie=mtie=1, ext_irq=tmr_irq=ecall=1 at pc 0x8000_0020 -> mcause 0x8000_0000_0000_000B, mepc 0x8000_0020, MIE=0, MPIE=1.
REQ-027 MIE=1, mtie=1, tmr_irq, mtvec 0x8000_0101 -> redirect 0x8000_011C; redirect_ready low 3 cycles -> redirect_valid/pc held, stall held.
REQ-028 rst_n low during T_CAUSE -> outputs 0 same cycle; no 0x300 write or redirect after release.
